tx_fifo_ctrl: RTL and testbench

Sequencer and arbiter in front of the 4-entry SSP transmit FIFO. It shares the FIFO write port between two byte requesters and drains the FIFO into the downstream serializer whenever that serializer is ready. It generates every FIFO strobe (PSEL_TX, PWRITE_TX, PWDATA_TX, CLEAR_B_TX) and tracks occupancy itself, so the FIFO is never written while full or read while empty.

---
 rtl/tx_fifo_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_tx_fifo_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_fifo_ctrl.sv
// Write-port arbiter and drain sequencer for the 4-entry SSP transmit FIFO.
// Optional build macro TX_FIFO_CTRL_STRICT_PRIO_EN: requester 0 always wins instead of round-robin.
module tx_fifo_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             PCLK,
  input  logic             CLEAR_B,
  input  logic             REQ0,
  input  logic [7:0]       WDATA0,
  output logic             GNT0,
  input  logic             REQ1,
  input  logic [7:0]       WDATA1,
  output logic             GNT1,
  input  logic             FLUSH,
  output logic             PSEL_TX,
  output logic             PWRITE_TX,
  output logic [7:0]       PWDATA_TX,
  output logic             CLEAR_B_TX,
  input  logic [7:0]       TxData,
  input  logic             SSPTXINTR,
  input  logic             SER_READY,
  output logic             SER_LOAD,
  output logic [7:0]       SER_DATA,
  output logic [CNT_W-1:0] COUNT
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WR,
    S_RD,
    S_CAP,
    S_FLUSH
  } state_t;

  state_t             state_q, state_d;
  logic               psel_q, psel_d;
  logic               pwrite_q, pwrite_d;
  logic [7:0]         pwdata_q, pwdata_d;
  logic               clrb_q, clrb_d;
  logic               gnt0_q, gnt0_d;
  logic               gnt1_q, gnt1_d;
  logic               ser_load_q, ser_load_d;
  logic [7:0]         ser_data_q, ser_data_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               flush_pend_q, flush_pend_d;
  logic               rd_ok, wr_ok, pick1;

`ifndef TX_FIFO_CTRL_STRICT_PRIO_EN
  // Pointer set means requester 1 holds priority on the next contested write.
  logic               rr_q, rr_d;
`endif

  assign rd_ok = (count_q != '0) && SER_READY;
  assign wr_ok = (REQ0 || REQ1) && (count_q < CNT_W'(DEPTH)) && !SSPTXINTR;

`ifdef TX_FIFO_CTRL_STRICT_PRIO_EN
  assign pick1 = REQ1 && !REQ0;
`else
  assign pick1 = REQ1 && (!REQ0 || rr_q);
`endif

  always_comb begin
    state_d      = state_q;
    psel_d       = 1'b0;
    pwrite_d     = 1'b0;
    pwdata_d     = pwdata_q;
    clrb_d       = 1'b1;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    ser_load_d   = 1'b0;
    ser_data_d   = ser_data_q;
    count_d      = count_q;
    flush_pend_d = flush_pend_q || FLUSH;
`ifndef TX_FIFO_CTRL_STRICT_PRIO_EN
    rr_d         = rr_q;
`endif
    case (state_q)
      S_INIT: begin
        // The FIFO only honours CLEAR_B_TX while selected, so clear it once here.
        psel_d       = 1'b1;
        clrb_d       = 1'b0;
        count_d      = '0;
        flush_pend_d = 1'b0;
        state_d      = S_IDLE;
      end
      S_IDLE: begin
        if (FLUSH || flush_pend_q) begin
          psel_d       = 1'b1;
          clrb_d       = 1'b0;
          count_d      = '0;
          flush_pend_d = 1'b0;
          state_d      = S_FLUSH;
        end else if (rd_ok) begin
          psel_d  = 1'b1;
          state_d = S_RD;
        end else if (wr_ok) begin
          psel_d   = 1'b1;
          pwrite_d = 1'b1;
          count_d  = count_q + CNT_W'(1);
          state_d  = S_WR;
          if (pick1) begin
            pwdata_d = WDATA1;
            gnt1_d   = 1'b1;
          end else begin
            pwdata_d = WDATA0;
            gnt0_d   = 1'b1;
          end
`ifndef TX_FIFO_CTRL_STRICT_PRIO_EN
          rr_d = !pick1;
`endif
        end
      end
      S_RD: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        // TxData is valid now; byte and load pulse leave together on the next edge.
        ser_data_d = TxData;
        ser_load_d = 1'b1;
        count_d    = count_q - CNT_W'(1);
        state_d    = S_IDLE;
      end
      S_WR, S_FLUSH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state_q      <= S_INIT;
      psel_q       <= 1'b0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= 8'h00;
      clrb_q       <= 1'b1;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      ser_load_q   <= 1'b0;
      ser_data_q   <= 8'h00;
      count_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      psel_q       <= psel_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      clrb_q       <= clrb_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      ser_load_q   <= ser_load_d;
      ser_data_q   <= ser_data_d;
      count_q      <= count_d;
      flush_pend_q <= flush_pend_d;
    end
  end

`ifndef TX_FIFO_CTRL_STRICT_PRIO_EN
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  assign PSEL_TX    = psel_q;
  assign PWRITE_TX  = pwrite_q;
  assign PWDATA_TX  = pwdata_q;
  assign CLEAR_B_TX = clrb_q;
  assign GNT0       = gnt0_q;
  assign GNT1       = gnt1_q;
  assign SER_LOAD   = ser_load_q;
  assign SER_DATA   = ser_data_q;
  assign COUNT      = count_q;

endmodule

// File: tb/tb_tx_fifo_ctrl.sv
// Directed bench for tx_fifo_ctrl with a small behavioural model of the 4-entry transmit FIFO.
module tb_tx_fifo_ctrl;

  logic       PCLK = 1'b0;
  logic       CLEAR_B = 1'b0;
  logic       REQ0 = 1'b0, REQ1 = 1'b0, FLUSH = 1'b0, SER_READY = 1'b0;
  logic [7:0] WDATA0 = 8'h00, WDATA1 = 8'h00;
  logic [7:0] TxData = 8'h00;
  logic       SSPTXINTR;
  logic       GNT0, GNT1, PSEL_TX, PWRITE_TX, CLEAR_B_TX, SER_LOAD;
  logic [7:0] PWDATA_TX, SER_DATA;
  logic [2:0] COUNT;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] fifo_q [$];
  int         fifo_n = 0;
  logic       force_full = 1'b0;

  tx_fifo_ctrl #(.DEPTH(4), .CNT_W(3)) dut (
    .PCLK(PCLK), .CLEAR_B(CLEAR_B),
    .REQ0(REQ0), .WDATA0(WDATA0), .GNT0(GNT0),
    .REQ1(REQ1), .WDATA1(WDATA1), .GNT1(GNT1),
    .FLUSH(FLUSH),
    .PSEL_TX(PSEL_TX), .PWRITE_TX(PWRITE_TX), .PWDATA_TX(PWDATA_TX), .CLEAR_B_TX(CLEAR_B_TX),
    .TxData(TxData), .SSPTXINTR(SSPTXINTR),
    .SER_READY(SER_READY), .SER_LOAD(SER_LOAD), .SER_DATA(SER_DATA),
    .COUNT(COUNT)
  );

  always #5 PCLK = ~PCLK;

  // FIFO model: acts on the edge following each strobe, read data valid the next cycle.
  assign SSPTXINTR = (fifo_n >= 4) || force_full;

  always @(posedge PCLK) begin
    if (PSEL_TX) begin
      if (!CLEAR_B_TX) begin
        fifo_q.delete();
        fifo_n <= 0;
      end else if (PWRITE_TX) begin
        fifo_q.push_back(PWDATA_TX);
        fifo_n <= fifo_n + 1;
      end else if (fifo_q.size() > 0) begin
        TxData <= fifo_q.pop_front();
        fifo_n <= fifo_n - 1;
      end
    end
  end

  task automatic apply_reset();
    @(negedge PCLK);
    CLEAR_B = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0; FLUSH = 1'b0; SER_READY = 1'b0; force_full = 1'b0;
    repeat (3) @(negedge PCLK);
    CLEAR_B = 1'b1;
    @(negedge PCLK);
    @(negedge PCLK);
  endtask

  task automatic fill_bytes(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input int n);
    logic [7:0] bytes [4];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    for (int i = 0; i < n; i++) begin
      bit got = 1'b0;
      REQ0 = 1'b1;
      WDATA0 = bytes[i];
      for (int t = 0; t < 10 && !got; t++) begin
        @(negedge PCLK);
        if (GNT0) got = 1'b1;
      end
      REQ0 = 1'b0;
      vectors++;
      if (got !== 1'b1) begin
        miscompares++;
        $display("FAIL fill_gnt0[%0d]: got no GNT0 within 10 cycles, required a grant", i);
      end
    end
    @(negedge PCLK);
  endtask

  task automatic test_reset();
    @(negedge PCLK);
    CLEAR_B = 1'b0;
    repeat (2) @(negedge PCLK);
    vectors++;
    if ({PSEL_TX, PWRITE_TX, CLEAR_B_TX, GNT0, GNT1, SER_LOAD} !== 6'b001000) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b required 001000",
               {PSEL_TX, PWRITE_TX, CLEAR_B_TX, GNT0, GNT1, SER_LOAD});
    end
    vectors++;
    if ({COUNT, SER_DATA, PWDATA_TX} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_data: got count=%0d ser=%h pw=%h required all 0", COUNT, SER_DATA, PWDATA_TX);
    end
    CLEAR_B = 1'b1;
    @(negedge PCLK);
    vectors++;
    if ({PSEL_TX, CLEAR_B_TX, PWRITE_TX} !== 3'b100) begin
      miscompares++;
      $display("FAIL init_clear: got psel,clrb,pwrite=%b required 100", {PSEL_TX, CLEAR_B_TX, PWRITE_TX});
    end
    @(negedge PCLK);
    vectors++;
    if ({PSEL_TX, CLEAR_B_TX, GNT0, GNT1, SER_LOAD, COUNT} !== 8'b01000000) begin
      miscompares++;
      $display("FAIL idle_after_init: got %b required 01000000",
               {PSEL_TX, CLEAR_B_TX, GNT0, GNT1, SER_LOAD, COUNT});
    end
  endtask

  task automatic test_single_write();
    apply_reset();
    REQ0 = 1'b1; WDATA0 = 8'hA1;
    @(negedge PCLK);
    vectors++;
    if ({GNT0, GNT1, PSEL_TX, PWRITE_TX, CLEAR_B_TX} !== 5'b10111 || PWDATA_TX !== 8'hA1 || COUNT !== 3'd1) begin
      miscompares++;
      $display("FAIL single_write: got gnt=%b%b psel=%b pw=%b clrb=%b data=%h count=%0d required 1,0,1,1,1,a1,1",
               GNT0, GNT1, PSEL_TX, PWRITE_TX, CLEAR_B_TX, PWDATA_TX, COUNT);
    end
    REQ0 = 1'b0;
    @(negedge PCLK);
    vectors++;
    if ({GNT0, PSEL_TX} !== 2'b00 || COUNT !== 3'd1) begin
      miscompares++;
      $display("FAIL single_write_after: got gnt0=%b psel=%b count=%0d required 0,0,1", GNT0, PSEL_TX, COUNT);
    end
  endtask

  task automatic test_arbitration();
    int ng = 0;
    int exp_id;
    apply_reset();
    REQ0 = 1'b1; REQ1 = 1'b1; WDATA0 = 8'h10; WDATA1 = 8'h20;
    for (int c = 0; c < 14; c++) begin
      @(negedge PCLK);
      if (GNT0 || GNT1) begin
`ifdef TX_FIFO_CTRL_STRICT_PRIO_EN
        exp_id = 0;
`else
        exp_id = ng % 2;
`endif
        ng++;
        vectors++;
        if ({GNT1, GNT0} !== ((exp_id == 1) ? 2'b10 : 2'b01) ||
            PWDATA_TX !== ((exp_id == 1) ? 8'h20 : 8'h10)) begin
          miscompares++;
          $display("FAIL arb_grant[%0d]: got gnt1,gnt0=%b data=%h required requester %0d",
                   ng, {GNT1, GNT0}, PWDATA_TX, exp_id);
        end
      end
    end
    vectors++;
    if (ng !== 4 || COUNT !== 3'd4 || SSPTXINTR !== 1'b1) begin
      miscompares++;
      $display("FAIL arb_full: got grants=%0d count=%0d full=%b required 4,4,1", ng, COUNT, SSPTXINTR);
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
  endtask

  task automatic test_drain();
    logic [7:0] exp_b [4];
    int nl = 0;
    int last = 0;
    exp_b[0] = 8'h10; exp_b[1] = 8'h20; exp_b[2] = 8'h30; exp_b[3] = 8'h40;
    apply_reset();
    fill_bytes(8'h10, 8'h20, 8'h30, 8'h40, 4);
    vectors++;
    if (COUNT !== 3'd4) begin
      miscompares++;
      $display("FAIL drain_prefill: got count=%0d required 4", COUNT);
    end
    SER_READY = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge PCLK);
      if (SER_LOAD) begin
        vectors++;
        if (nl >= 4 || SER_DATA !== exp_b[nl[1:0]] || (nl > 0 && c - last != 3)) begin
          miscompares++;
          $display("FAIL drain_load[%0d]: got data=%h gap=%0d required data=%h gap=3",
                   nl, SER_DATA, c - last, exp_b[nl[1:0]]);
        end
        nl++;
        last = c;
      end
    end
    vectors++;
    if (nl !== 4 || COUNT !== 3'd0 || SER_DATA !== 8'h40) begin
      miscompares++;
      $display("FAIL drain_end: got loads=%0d count=%0d data=%h required 4,0,40", nl, COUNT, SER_DATA);
    end
    SER_READY = 1'b0;
  endtask

  task automatic test_flush_during_rd();
    apply_reset();
    fill_bytes(8'h55, 8'h66, 8'h77, 8'h00, 3);
    vectors++;
    if (COUNT !== 3'd3) begin
      miscompares++;
      $display("FAIL flush_prefill: got count=%0d required 3", COUNT);
    end
    SER_READY = 1'b1;
    @(negedge PCLK);
    vectors++;
    if ({PSEL_TX, PWRITE_TX, CLEAR_B_TX} !== 3'b101) begin
      miscompares++;
      $display("FAIL flush_rd_strobe: got psel,pwrite,clrb=%b required 101", {PSEL_TX, PWRITE_TX, CLEAR_B_TX});
    end
    FLUSH = 1'b1; SER_READY = 1'b0;
    @(negedge PCLK);
    FLUSH = 1'b0;
    @(negedge PCLK);
    vectors++;
    if (SER_LOAD !== 1'b1 || SER_DATA !== 8'h55 || COUNT !== 3'd2) begin
      miscompares++;
      $display("FAIL flush_cap: got load=%b data=%h count=%0d required 1,55,2", SER_LOAD, SER_DATA, COUNT);
    end
    @(negedge PCLK);
    vectors++;
    if ({PSEL_TX, CLEAR_B_TX} !== 2'b10 || COUNT !== 3'd0) begin
      miscompares++;
      $display("FAIL flush_clear: got psel,clrb=%b count=%0d required 10,0", {PSEL_TX, CLEAR_B_TX}, COUNT);
    end
    @(negedge PCLK);
    vectors++;
    if ({PSEL_TX, CLEAR_B_TX, SER_LOAD} !== 3'b010 || fifo_n !== 0) begin
      miscompares++;
      $display("FAIL flush_after: got psel,clrb,load=%b fifo_n=%0d required 010,0",
               {PSEL_TX, CLEAR_B_TX, SER_LOAD}, fifo_n);
    end
  endtask

  task automatic test_full_mismatch();
    int ng = 0;
    bit got = 1'b0;
    apply_reset();
    force_full = 1'b1;
    REQ1 = 1'b1; WDATA1 = 8'h99;
    for (int c = 0; c < 6; c++) begin
      @(negedge PCLK);
      if (GNT0 || GNT1 || PSEL_TX) ng++;
    end
    vectors++;
    if (ng !== 0 || COUNT !== 3'd0) begin
      miscompares++;
      $display("FAIL mismatch_block: got %0d strobe cycles count=%0d required 0,0", ng, COUNT);
    end
    FLUSH = 1'b1; force_full = 1'b0;
    @(negedge PCLK);
    FLUSH = 1'b0;
    vectors++;
    if ({PSEL_TX, CLEAR_B_TX, GNT1} !== 3'b100) begin
      miscompares++;
      $display("FAIL mismatch_flush: got psel,clrb,gnt1=%b required 100", {PSEL_TX, CLEAR_B_TX, GNT1});
    end
    for (int t = 0; t < 6 && !got; t++) begin
      @(negedge PCLK);
      if (GNT1) got = 1'b1;
    end
    vectors++;
    if (got !== 1'b1 || PWDATA_TX !== 8'h99 || COUNT !== 3'd1) begin
      miscompares++;
      $display("FAIL mismatch_release: got gnt1=%b data=%h count=%0d required 1,99,1", got, PWDATA_TX, COUNT);
    end
    REQ1 = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    fill_bytes(8'hC3, 8'h00, 8'h00, 8'h00, 1);
    SER_READY = 1'b1;
    @(negedge PCLK);
    CLEAR_B = 1'b0;
    #1;
    vectors++;
    if ({PSEL_TX, SER_LOAD, CLEAR_B_TX} !== 3'b001 || COUNT !== 3'd0) begin
      miscompares++;
      $display("FAIL midop_reset: got psel,load,clrb=%b count=%0d required 001,0",
               {PSEL_TX, SER_LOAD, CLEAR_B_TX}, COUNT);
    end
    SER_READY = 1'b0;
    @(negedge PCLK);
    CLEAR_B = 1'b1;
    @(negedge PCLK);
    vectors++;
    if ({PSEL_TX, CLEAR_B_TX, SER_LOAD} !== 3'b100) begin
      miscompares++;
      $display("FAIL midop_reinit: got psel,clrb,load=%b required 100", {PSEL_TX, CLEAR_B_TX, SER_LOAD});
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_arbitration();
    test_drain();
    test_flush_during_rd();
    test_full_mismatch();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
